// File: rtl/io_pad_ctrl.sv
// Core-side controller for a bank of io_cell pads: direction sequencing with a
// one-cycle pre-drive phase, input synchronise/debounce, edge pulses, sticky flags and irq.
module io_pad_ctrl #(
   parameter int unsigned NUM_PADS   = 8,
   parameter int unsigned CONF_WIDTH = 3,
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PADS-1:0]                dir_i,
   input  logic [NUM_PADS-1:0]                out_i,
   input  logic [NUM_PADS*(CONF_WIDTH-1)-1:0] cfg_extra_i,
   input  logic [NUM_PADS-1:0]                edge_en_i,
   input  logic [NUM_PADS-1:0]                flag_clr_i,
   output logic [NUM_PADS*CONF_WIDTH-1:0]     io_cell_cfg_o,
   output logic [NUM_PADS-1:0]                from_core_o,
   input  logic [NUM_PADS-1:0]                to_core_i,
   output logic [NUM_PADS-1:0]                in_o,
   output logic [NUM_PADS-1:0]                rise_o,
   output logic [NUM_PADS-1:0]                fall_o,
   output logic [NUM_PADS-1:0]                flag_o,
   output logic                               irq_o
);

   localparam int unsigned XW = CONF_WIDTH - 1;
   localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IN      = 2'd0,
      ST_PRE_OUT = 2'd1,
      ST_OUT     = 2'd2
   } dir_state_e;

   dir_state_e state_q [NUM_PADS];
   dir_state_e state_d [NUM_PADS];
   logic [7:0] cnt_q   [NUM_PADS];
   logic [7:0] cnt_d   [NUM_PADS];

   logic [NUM_PADS-1:0]      cfg0_q, cfg0_d;
   logic [NUM_PADS-1:0]      from_core_q, from_core_d;
   logic [NUM_PADS*XW-1:0]   cfg_extra_q;
   logic [NUM_PADS-1:0]      sync1_q, sync2_q;
   logic [NUM_PADS-1:0]      in_q, in_d;
   logic [NUM_PADS-1:0]      rise_q, rise_d;
   logic [NUM_PADS-1:0]      fall_q, fall_d;
   logic [NUM_PADS-1:0]      flag_q, flag_d;
   logic                     irq_q;

   always_comb begin
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
         state_d[n]     = state_q[n];
         cfg0_d[n]      = cfg0_q[n];
         from_core_d[n] = from_core_q[n];
         cnt_d[n]       = cnt_q[n];
         in_d[n]        = in_q[n];
         rise_d[n]      = 1'b0;
         fall_d[n]      = 1'b0;

         unique case (state_q[n])
            ST_IN: begin
               if (dir_i[n]) begin
                  state_d[n]     = ST_PRE_OUT;
                  from_core_d[n] = out_i[n];
               end
            end
            ST_PRE_OUT: begin
               if (dir_i[n]) begin
                  state_d[n]     = ST_OUT;
                  cfg0_d[n]      = 1'b0;
                  from_core_d[n] = out_i[n];
               end else begin
                  state_d[n] = ST_IN;
               end
            end
            ST_OUT: begin
               if (dir_i[n]) begin
                  from_core_d[n] = out_i[n];
               end else begin
                  state_d[n] = ST_IN;
                  cfg0_d[n]  = 1'b1;
               end
            end
            default: begin
               state_d[n] = ST_IN;
               cfg0_d[n]  = 1'b1;
            end
         endcase

         // io_cell reads back 0 while driving, so debounce only runs in input mode
         if (state_q[n] != ST_IN || sync2_q[n] == in_q[n]) begin
            cnt_d[n] = '0;
         end else if (cnt_q[n] >= DEB_LAST) begin
            cnt_d[n]  = '0;
            in_d[n]   = sync2_q[n];
            rise_d[n] = sync2_q[n];
            fall_d[n] = ~sync2_q[n];
         end else if (cnt_q[n] != '1) begin
            cnt_d[n] = cnt_q[n] + 8'd1;
         end
      end

      flag_d = (flag_q & ~flag_clr_i) | ((rise_q | fall_q) & edge_en_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned n = 0; n < NUM_PADS; n++) begin
            state_q[n] <= ST_IN;
            cnt_q[n]   <= '0;
         end
         cfg0_q      <= '1;
         from_core_q <= '0;
         cfg_extra_q <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         in_q        <= '0;
         rise_q      <= '0;
         fall_q      <= '0;
         flag_q      <= '0;
         irq_q       <= 1'b0;
      end else begin
         for (int unsigned n = 0; n < NUM_PADS; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
         cfg0_q      <= cfg0_d;
         from_core_q <= from_core_d;
         cfg_extra_q <= cfg_extra_i;
         sync1_q     <= to_core_i;
         sync2_q     <= sync1_q;
         in_q        <= in_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         flag_q      <= flag_d;
         irq_q       <= |flag_q;
      end
   end

   always_comb begin
      io_cell_cfg_o = '0;
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
         io_cell_cfg_o[n*CONF_WIDTH +: CONF_WIDTH] = {cfg_extra_q[n*XW +: XW], cfg0_q[n]};
      end
   end

   assign from_core_o = from_core_q;
   assign in_o        = in_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;
   assign flag_o      = flag_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Directed bench for io_pad_ctrl: direction sequencing, debounce timing, edges, flags, reset.
module tb_io_pad_ctrl;

   localparam int unsigned NP = 8;
   localparam int unsigned CW = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NP-1:0]          dir_i, out_i, edge_en_i, flag_clr_i, to_core_i;
   logic [NP*(CW-1)-1:0]   cfg_extra_i;
   logic [NP*CW-1:0]       io_cell_cfg_o;
   logic [NP-1:0]          from_core_o, in_o, rise_o, fall_o, flag_o;
   logic                   irq_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   io_pad_ctrl #(.NUM_PADS(NP), .CONF_WIDTH(CW), .DEB_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .dir_i(dir_i), .out_i(out_i), .cfg_extra_i(cfg_extra_i),
      .edge_en_i(edge_en_i), .flag_clr_i(flag_clr_i), .io_cell_cfg_o(io_cell_cfg_o),
      .from_core_o(from_core_o), .to_core_i(to_core_i), .in_o(in_o), .rise_o(rise_o),
      .fall_o(fall_o), .flag_o(flag_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cfg0();
      logic [7:0] r = '0;
      for (int n = 0; n < NP; n++) r[n] = io_cell_cfg_o[n*CW];
      return r;
   endfunction

   function automatic logic [15:0] cfgx();
      logic [15:0] r = '0;
      for (int n = 0; n < NP; n++) r[n*2 +: 2] = io_cell_cfg_o[n*CW+1 +: 2];
      return r;
   endfunction

   initial begin
      logic [15:0] x;
      rst = 1'b1; dir_i = 8'hFF; out_i = 8'hA5; cfg_extra_i = '0;
      edge_en_i = 8'hFF; flag_clr_i = '0; to_core_i = '0;
      repeat (3) tick();

      // 1: reset state with drive requested, then enable sequencing
      chk("rst_cfg0", cfg0(), 8'hFF);
      x = cfgx();
      chk("rst_cfgx_lo", x[7:0], 8'h00);
      chk("rst_cfgx_hi", x[15:8], 8'h00);
      chk("rst_from_core", from_core_o, 8'h00);
      chk("rst_in", in_o, 8'h00);
      chk("rst_pulses", rise_o | fall_o, 8'h00);
      chk("rst_flag", flag_o, 8'h00);
      chk("rst_irq", {7'b0, irq_o}, 8'h00);
      rst = 1'b0; cfg_extra_i = 16'hBEEF;
      tick();
      chk("c1_from_core", from_core_o, 8'hA5);
      chk("c1_cfg0", cfg0(), 8'hFF);
      x = cfgx();
      chk("c1_cfgx_lo", x[7:0], 8'hEF);
      chk("c1_cfgx_hi", x[15:8], 8'hBE);
      tick();
      chk("c2_cfg0", cfg0(), 8'h00);
      out_i = 8'h3C;
      tick();
      chk("out_follow", from_core_o, 8'h3C);

      // 2: release pad0, then a 1,0 toggle must never enable its driver
      dir_i = 8'hFE;
      tick();
      chk("release_cfg0", cfg0(), 8'h01);
      dir_i = 8'hFF;
      tick();
      chk("toggle_a_cfg0", cfg0(), 8'h01);
      dir_i = 8'hFE;
      tick();
      chk("toggle_b_cfg0", cfg0(), 8'h01);
      tick();
      chk("toggle_c_cfg0", cfg0(), 8'h01);
      dir_i = 8'h00; out_i = 8'h00;
      tick();
      chk("all_in_cfg0", cfg0(), 8'hFF);
      chk("hold_from_core", from_core_o, 8'h3C);

      // 3: debounced rise on pad1 after 2 + DEB_CYCLES cycles
      to_core_i = 8'h02;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("deb_wait_in", in_o, 8'h00);
      end
      tick();
      chk("deb_in", in_o, 8'h02);
      chk("deb_rise", rise_o, 8'h02);
      chk("deb_flag_not_yet", flag_o, 8'h00);
      tick();
      chk("rise_once", rise_o, 8'h00);
      chk("flag_set", flag_o, 8'h02);
      chk("irq_lag", {7'b0, irq_o}, 8'h00);
      tick();
      chk("irq_set", {7'b0, irq_o}, 8'h01);

      // 4: 3-cycle glitch on pad2 is rejected
      to_core_i = 8'h06;
      repeat (3) tick();
      to_core_i = 8'h02;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_in", in_o, 8'h02);
         chk("glitch_pulse", rise_o | fall_o, 8'h00);
      end
      chk("glitch_flag", flag_o, 8'h02);

      // 5: clear coinciding with a new edge loses; clear alone wins
      to_core_i = 8'h00;
      repeat (5) tick();
      chk("fall_wait", fall_o, 8'h00);
      tick();
      chk("fall_pulse", fall_o, 8'h02);
      chk("fall_in", in_o, 8'h00);
      flag_clr_i = 8'h02;
      tick();
      flag_clr_i = 8'h00;
      chk("set_wins", flag_o, 8'h02);
      tick();
      flag_clr_i = 8'h02;
      tick();
      flag_clr_i = 8'h00;
      chk("clr_flag", flag_o, 8'h00);
      chk("clr_irq_lag", {7'b0, irq_o}, 8'h01);
      tick();
      chk("clr_irq", {7'b0, irq_o}, 8'h00);

      // 6: edges with flags disabled, then reset during a debounce count
      edge_en_i = 8'h00;
      to_core_i = 8'h08;
      repeat (6) tick();
      chk("noen_rise", rise_o, 8'h08);
      chk("noen_in", in_o, 8'h08);
      tick();
      chk("noen_flag", flag_o, 8'h00);
      to_core_i = 8'h00;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("midrst_in", in_o, 8'h00);
      chk("midrst_cfg0", cfg0(), 8'hFF);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("post_rst_in", in_o, 8'h00);
         chk("post_rst_pulse", rise_o | fall_o, 8'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
